// File: rtl/hex_display_scheduler_pkg.sv
// Shared constants, override state type and scan helper for the HEX display scheduler.
// The scan always covers the six board displays HEX0..HEX5.
package hex_display_scheduler_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int SCAN_W     = 3;

    typedef logic [SCAN_W-1:0] scan_idx_t;

    localparam scan_idx_t  LAST_DIGIT   = 3'd5;
    localparam logic [6:0] SEG_BLANK    = 7'h7F;
    localparam logic [3:0] NIB_DICE_TAG = 4'hD;
    localparam logic [3:0] NIB_WIN_TAG  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DICE = 2'd1,
        WIN  = 2'd2
    } ovr_state_t;

    function automatic scan_idx_t scan_next(input scan_idx_t idx);
        return (idx == LAST_DIGIT) ? scan_idx_t'(0) : idx + scan_idx_t'(1);
    endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Requester inputs and display outputs of the HEX display scheduler.
// master = game logic / board side, slave = scheduler.
interface hex_display_scheduler_if;

    logic [7:0] pos_p1_bcd;
    logic [7:0] pos_p2_bcd;
    logic       dice_req;
    logic [3:0] dice_val;
    logic       dice_ack;
    logic       win_req;
    logic [1:0] win_player;
    logic       new_game;
    logic       blank;
    logic [6:0] hex0;
    logic [6:0] hex1;
    logic [6:0] hex2;
    logic [6:0] hex3;
    logic [6:0] hex4;
    logic [6:0] hex5;
    logic       frame_done;

    modport master (
        output pos_p1_bcd, pos_p2_bcd, dice_req, dice_val,
        output win_req, win_player, new_game, blank,
        input  dice_ack, hex0, hex1, hex2, hex3, hex4, hex5, frame_done
    );

    modport slave (
        input  pos_p1_bcd, pos_p2_bcd, dice_req, dice_val,
        input  win_req, win_player, new_game, blank,
        output dice_ack, hex0, hex1, hex2, hex3, hex4, hex5, frame_done
    );

endinterface

// File: rtl/hex_display_scheduler_seg.sv
// HEX_seg: combinational nibble to active-low 7-segment decoder, seg[0]=a .. seg[6]=g.
// Values above 9 decode as hex letters A, b, C, d, E, F.
module hex_display_scheduler_seg (
    input  logic       c0,
    input  logic       c1,
    input  logic       c2,
    input  logic       c3,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case ({c3, c2, c1, c0})
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/hex_display_scheduler.sv
// Scans one shared HEX_seg decoder over HEX0..HEX5, one digit per clock, arbitrating
// player positions (background), a timed dice override and a sticky winner override.
module hex_display_scheduler
    import hex_display_scheduler_pkg::*;
#(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                    clk,
    input  logic                    reset,
    hex_display_scheduler_if.slave  bus
);

    localparam int              CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

    scan_idx_t        idx_reg;
    ovr_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       dice_val_reg;
    logic [1:0]       win_player_reg;
    logic             dice_ack_reg;
    logic             frame_done_reg;

    logic             dice_accept;
    logic             show_dice;
    logic             show_win;
    logic [3:0]       cur_nib;
    logic             cur_dark;
    logic [6:0]       dec_seg;
    logic [6:0]       cur_word;
    logic [6:0]       hex_word [NUM_DIGITS];

    // new_game wins over a coincident dice request, so that request is dropped unacked.
    assign dice_accept = bus.dice_req & ~bus.new_game;

    always_comb begin
        cnt_next = cnt_reg;
        if (bus.new_game) begin
            cnt_next = '0;
        end else if (dice_accept) begin
            cnt_next = HOLD_LOAD;
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg        <= '0;
            dice_val_reg   <= '0;
            win_player_reg <= '0;
            dice_ack_reg   <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            dice_ack_reg <= dice_accept;
            if (dice_accept) begin
                dice_val_reg <= bus.dice_val;
            end
            if (bus.win_req && !bus.new_game) begin
                win_player_reg <= bus.win_player;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The counter keeps running in WIN; it only decides when DICE falls back to IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.win_req) begin
                    state_next = WIN;
                end else if (dice_accept) begin
                    state_next = DICE;
                end
            end
            DICE: begin
                if (bus.win_req) begin
                    state_next = WIN;
                end else if (cnt_next == '0) begin
                    state_next = IDLE;
                end
            end
            WIN:     state_next = WIN;
            default: state_next = IDLE;
        endcase
        if (bus.new_game) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        show_win  = 1'b0;
        show_dice = 1'b0;
        case (state_reg)
            WIN:     show_win  = 1'b1;
            DICE:    show_dice = 1'b1;
            default: ;
        endcase
    end

    // Nibble and dark flag for the digit being scanned this cycle.
    always_comb begin
        cur_nib  = 4'h0;
        cur_dark = 1'b0;
        case (idx_reg)
            3'd0: cur_nib = bus.pos_p1_bcd[3:0];
            3'd1: begin
                cur_nib  = bus.pos_p1_bcd[7:4];
                cur_dark = (bus.pos_p1_bcd[7:4] == 4'h0);
            end
            3'd2: cur_nib = bus.pos_p2_bcd[3:0];
            3'd3: begin
                cur_nib  = bus.pos_p2_bcd[7:4];
                cur_dark = (bus.pos_p2_bcd[7:4] == 4'h0);
            end
            3'd4: begin
                if (show_win) begin
                    cur_nib = {2'b00, win_player_reg};
                end else if (show_dice) begin
                    cur_nib = dice_val_reg;
                end else begin
                    cur_dark = 1'b1;
                end
            end
            3'd5: begin
                if (show_win) begin
                    cur_nib = NIB_WIN_TAG;
                end else if (show_dice) begin
                    cur_nib = NIB_DICE_TAG;
                end else begin
                    cur_dark = 1'b1;
                end
            end
            default: cur_dark = 1'b1;
        endcase
        if (bus.blank) begin
            cur_dark = 1'b1;
        end
    end

    hex_display_scheduler_seg u_seg (
        .c0  (cur_nib[0]),
        .c1  (cur_nib[1]),
        .c2  (cur_nib[2]),
        .c3  (cur_nib[3]),
        .seg (dec_seg)
    );

    assign cur_word = cur_dark ? SEG_BLANK : dec_seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg        <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            idx_reg        <= scan_next(idx_reg);
            frame_done_reg <= (idx_reg == LAST_DIGIT);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [6:0] seg_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    seg_reg <= SEG_BLANK;
                end else if (idx_reg == scan_idx_t'(gi)) begin
                    seg_reg <= cur_word;
                end
            end

            assign hex_word[gi] = seg_reg;
        end
    endgenerate

    assign bus.hex0       = hex_word[0];
    assign bus.hex1       = hex_word[1];
    assign bus.hex2       = hex_word[2];
    assign bus.hex3       = hex_word[3];
    assign bus.hex4       = hex_word[4];
    assign bus.hex5       = hex_word[5];
    assign bus.dice_ack   = dice_ack_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Randomized scoreboard bench for hex_display_scheduler: a behavioural model predicts each
// scanned frame and every dice acknowledge; a monitor compares them as the DUT presents them.
module tb_hex_display_scheduler;

    localparam int HOLD = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hex_display_scheduler_if bus ();

    hex_display_scheduler #(.HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Active-low a..g patterns for 0..9, A, b, C, d, E, F.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: sticky winner, remaining dice hold clocks, position within the frame.
    bit          win_flag;
    logic [1:0]  win_pl;
    int          dice_left;
    logic [3:0]  dice_v;
    int          digit;
    int          cyc;
    logic [41:0] frame_build;
    logic [41:0] frame_q [$];
    int          ack_q [$];
    int          frames_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] tens_word(input logic [3:0] nib);
        return (nib == 4'h0) ? 7'h7F : seg_tab[nib];
    endfunction

    function automatic logic [6:0] expect_word(input int d);
        if (bus.blank) return 7'h7F;
        case (d)
            0: return seg_tab[bus.pos_p1_bcd[3:0]];
            1: return tens_word(bus.pos_p1_bcd[7:4]);
            2: return seg_tab[bus.pos_p2_bcd[3:0]];
            3: return tens_word(bus.pos_p2_bcd[7:4]);
            default: begin
                if (win_flag) return (d == 5) ? seg_tab[15] : seg_tab[{2'b00, win_pl}];
                if (dice_left > 0) return (d == 5) ? seg_tab[13] : seg_tab[dice_v];
                return 7'h7F;
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            win_flag  = 1'b0;
            dice_left = 0;
            digit     = 0;
            cyc       = 0;
            frame_q.delete();
            ack_q.delete();
        end else begin
            cyc++;
            frame_build[digit*7 +: 7] = expect_word(digit);
            if (digit == 5) frame_q.push_back(frame_build);
            digit = (digit + 1) % 6;
            if (bus.new_game) begin
                win_flag  = 1'b0;
                dice_left = 0;
            end else begin
                if (bus.dice_req) begin
                    dice_v    = bus.dice_val;
                    dice_left = HOLD;
                    ack_q.push_back(cyc);
                end else if (dice_left > 0) begin
                    dice_left--;
                end
                if (bus.win_req) begin
                    win_flag = 1'b1;
                    win_pl   = bus.win_player;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_q.size() > 1) begin
                errors++;
                $display("FAIL frame_done_missing: got no pulse, expected one (cycle %0d)", cyc);
                void'(frame_q.pop_front());
            end
            if (bus.frame_done) begin
                if (frame_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_done_extra: got pulse, expected none (cycle %0d)", cyc);
                end else begin
                    logic [41:0] f;
                    f = frame_q.pop_front();
                    frames_seen++;
                    check("hex0", bus.hex0, f[6:0]);
                    check("hex1", bus.hex1, f[13:7]);
                    check("hex2", bus.hex2, f[20:14]);
                    check("hex3", bus.hex3, f[27:21]);
                    check("hex4", bus.hex4, f[34:28]);
                    check("hex5", bus.hex5, f[41:35]);
                    $display("frame %0d cycle %0d: %h %h %h %h %h %h", frames_seen, cyc,
                             bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0);
                end
            end
            while (ack_q.size() > 0 && ack_q[0] < cyc) begin
                errors++;
                $display("FAIL dice_ack_missing: got 0, expected 1 (cycle %0d)", ack_q[0]);
                void'(ack_q.pop_front());
            end
            if (bus.dice_ack) begin
                if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL dice_ack_spurious: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    check("dice_ack_cycle", cyc, ack_q.pop_front());
                    $display("dice ack at cycle %0d", cyc);
                end
            end
        end
    end

    task automatic idle_inputs();
        bus.dice_req = 1'b0;
        bus.win_req  = 1'b0;
        bus.new_game = 1'b0;
    endtask

    task automatic dice(input logic [3:0] v);
        bus.dice_req = 1'b1;
        bus.dice_val = v;
        @(negedge clk);
        bus.dice_req = 1'b0;
        check("dice_ack_direct", bus.dice_ack, 1);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset          = 1'b1;
        bus.pos_p1_bcd = 8'h00;
        bus.pos_p2_bcd = 8'h00;
        bus.dice_val   = 4'h1;
        bus.win_player = 2'd1;
        bus.blank      = 1'b0;
        idle_inputs();

        repeat (2) @(negedge clk);
        check("rst_hex0", bus.hex0, 7'h7F);
        check("rst_hex3", bus.hex3, 7'h7F);
        check("rst_hex5", bus.hex5, 7'h7F);
        check("rst_frame_done", bus.frame_done, 0);
        check("rst_dice_ack", bus.dice_ack, 0);
        reset = 1'b0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 20);
        check("first_frame_latency", n, 6);

        bus.pos_p1_bcd = 8'h05;
        bus.pos_p2_bcd = 8'h31;
        wait_clk(7);
        check("bg_hex0", bus.hex0, 7'h12);
        check("bg_hex1", bus.hex1, 7'h7F);
        check("bg_hex2", bus.hex2, 7'h79);
        check("bg_hex3", bus.hex3, 7'h30);
        check("bg_hex4", bus.hex4, 7'h7F);
        check("bg_hex5", bus.hex5, 7'h7F);

        dice(4'd3);
        wait_clk(6);
        check("dice_hex5", bus.hex5, 7'h21);
        check("dice_hex4", bus.hex4, 7'h30);
        wait_clk(15);
        check("dice_end_hex5", bus.hex5, 7'h7F);
        check("dice_end_hex4", bus.hex4, 7'h7F);

        dice(4'd3);
        wait_clk(3);
        dice(4'd1);
        wait_clk(6);
        check("redice_hex4", bus.hex4, 7'h79);

        bus.win_req    = 1'b1;
        bus.win_player = 2'd1;
        @(negedge clk);
        bus.win_req = 1'b0;
        wait_clk(7);
        check("win_hex5", bus.hex5, 7'h0E);
        check("win_hex4", bus.hex4, 7'h79);
        wait_clk(15);
        check("win_sticky_hex5", bus.hex5, 7'h0E);
        check("win_sticky_hex4", bus.hex4, 7'h79);
        bus.new_game = 1'b1;
        @(negedge clk);
        bus.new_game = 1'b0;
        wait_clk(7);
        check("newgame_hex5", bus.hex5, 7'h7F);
        check("newgame_hex4", bus.hex4, 7'h7F);

        bus.pos_p1_bcd = 8'h10;
        bus.blank      = 1'b1;
        wait_clk(7);
        check("blank_hex0", bus.hex0, 7'h7F);
        check("blank_hex2", bus.hex2, 7'h7F);
        bus.blank = 1'b0;
        wait_clk(7);
        check("unblank_hex0", bus.hex0, 7'h40);
        check("unblank_hex1", bus.hex1, 7'h79);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            bus.dice_req = ($urandom_range(0, 9) == 0);
            bus.dice_val = 4'($urandom_range(1, 6));
            bus.win_req  = ($urandom_range(0, 39) == 0);
            bus.win_player = 2'($urandom_range(1, 2));
            bus.new_game = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 24) == 0) bus.blank = ~bus.blank;
            if ($urandom_range(0, 14) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    bus.pos_p1_bcd = 8'($urandom_range(0, 255));
                    bus.pos_p2_bcd = 8'($urandom_range(0, 255));
                end else begin
                    bus.pos_p1_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    bus.pos_p2_bcd = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                end
            end
        end

        @(negedge clk);
        idle_inputs();
        wait_clk(12);
        check("ack_queue_drained", ack_q.size(), 0);
        check("frame_queue_drained", (frame_q.size() <= 1) ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
